// File: rtl/lenet_pkg.sv
// Shared LeNet accelerator definitions: layer-sequencer state encoding and
// default DRAM port widths.
package lenet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_GAP  = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd7
  } seq_state_t;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 18;

endpackage

// File: rtl/dram_port_mux.sv
// Forwards the DRAM port of the engine selected by a one-hot vector; an
// all-zero select drives every output to 0.
module dram_port_mux #(
  parameter int NUM_STAGES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
) (
  input  logic [NUM_STAGES-1:0]            sel,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] sub_data_out,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] sub_addr_in,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] sub_addr_out,
  input  logic [NUM_STAGES-1:0]            sub_en_wr,
  input  logic [NUM_STAGES-1:0]            sub_en_rd,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [ADDR_WIDTH-1:0]            addr_in,
  output logic [ADDR_WIDTH-1:0]            addr_out,
  output logic                             dram_en_wr,
  output logic                             dram_en_rd
);

  logic [DATA_WIDTH-1:0] data_arr     [NUM_STAGES];
  logic [ADDR_WIDTH-1:0] addr_in_arr  [NUM_STAGES];
  logic [ADDR_WIDTH-1:0] addr_out_arr [NUM_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_slice
      assign data_arr[gi]     = sub_data_out[gi*DATA_WIDTH +: DATA_WIDTH];
      assign addr_in_arr[gi]  = sub_addr_in[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign addr_out_arr[gi] = sub_addr_out[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // AND-OR selection: one-hot select avoids a wide index decode.
  always_comb begin
    data_out = '0;
    addr_in  = '0;
    addr_out = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (sel[k]) begin
        data_out = data_out | data_arr[k];
        addr_in  = addr_in  | addr_in_arr[k];
        addr_out = addr_out | addr_out_arr[k];
      end
    end
  end

  assign dram_en_wr = |(sel & sub_en_wr);
  assign dram_en_rd = |(sel & sub_en_rd);

endmodule

// File: rtl/layer_seq.sv
// Runs attached layer engines one after another, owning the shared DRAM port.
// Optional per-stage watchdog enabled by macro LAYER_SEQ_TIMEOUT_EN.
module layer_seq
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int NUM_STAGES     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int STG_W          = $clog2(NUM_STAGES + 1)
) (
  input  logic                             clk,
  input  logic                             srstn,
  input  logic                             enable,
  input  logic                             abort,
  input  logic [STG_W-1:0]                 num_stages_cfg,
  input  logic [NUM_STAGES-1:0]            sub_done,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] sub_data_out,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] sub_addr_in,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] sub_addr_out,
  input  logic [NUM_STAGES-1:0]            sub_en_wr,
  input  logic [NUM_STAGES-1:0]            sub_en_rd,
  output logic [NUM_STAGES-1:0]            sub_en,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic [ADDR_WIDTH-1:0]            addr_in,
  output logic [ADDR_WIDTH-1:0]            addr_out,
  output logic                             dram_en_wr,
  output logic                             dram_en_rd,
  output logic [STG_W-1:0]                 stage_idx,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam logic [STG_W-1:0] MAX_STG = STG_W'(NUM_STAGES);

  seq_state_t       state_reg;
  logic [STG_W-1:0] stage_idx_reg;
  logic [STG_W-1:0] cfg_reg;
  logic [STG_W-1:0] cfg_clamped;
  logic             stage_done;

`ifdef LAYER_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] timeout_reg;
`endif

  assign cfg_clamped = (num_stages_cfg > MAX_STG) ? MAX_STG : num_stages_cfg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_en
      assign sub_en[gi] = (state_reg == ST_RUN) && (stage_idx_reg == STG_W'(gi));
    end
  endgenerate

  // Masking with the one-hot enable ignores every done bit but the active one.
  assign stage_done = |(sub_done & sub_en);

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_reg     <= ST_IDLE;
      stage_idx_reg <= '0;
      cfg_reg       <= '0;
`ifdef LAYER_SEQ_TIMEOUT_EN
      timeout_reg   <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            cfg_reg       <= cfg_clamped;
            stage_idx_reg <= '0;
            state_reg     <= (cfg_clamped == '0) ? ST_DONE : ST_RUN;
`ifdef LAYER_SEQ_TIMEOUT_EN
            timeout_reg   <= '0;
`endif
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_reg     <= ST_IDLE;
            stage_idx_reg <= '0;
          end else if (stage_done) begin
            if (stage_idx_reg == cfg_reg - STG_W'(1)) begin
              state_reg <= ST_DONE;
            end else begin
              stage_idx_reg <= stage_idx_reg + STG_W'(1);
              state_reg     <= ST_GAP;
            end
          end
`ifdef LAYER_SEQ_TIMEOUT_EN
          else if (timeout_reg == TO_LAST) begin
            state_reg <= ST_ERR;
          end else begin
            timeout_reg <= timeout_reg + TO_W'(1);
          end
`endif
        end
        ST_GAP: begin
          if (abort) begin
            state_reg     <= ST_IDLE;
            stage_idx_reg <= '0;
          end else begin
            state_reg <= ST_RUN;
`ifdef LAYER_SEQ_TIMEOUT_EN
            timeout_reg <= '0;
`endif
          end
        end
        default: begin
          state_reg     <= ST_IDLE;
          stage_idx_reg <= '0;
        end
      endcase
    end
  end

  assign stage_idx = stage_idx_reg;
  assign busy      = (state_reg == ST_RUN) || (state_reg == ST_GAP);
  assign done      = (state_reg == ST_DONE);
`ifdef LAYER_SEQ_TIMEOUT_EN
  assign error     = (state_reg == ST_ERR);
`else
  assign error     = 1'b0;
`endif

  dram_port_mux #(
    .NUM_STAGES (NUM_STAGES),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mux (
    .sel          (sub_en),
    .sub_data_out (sub_data_out),
    .sub_addr_in  (sub_addr_in),
    .sub_addr_out (sub_addr_out),
    .sub_en_wr    (sub_en_wr),
    .sub_en_rd    (sub_en_rd),
    .data_out     (data_out),
    .addr_in      (addr_in),
    .addr_out     (addr_out),
    .dram_en_wr   (dram_en_wr),
    .dram_en_rd   (dram_en_rd)
  );

endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq with four engines; the watchdog scenario is
// exercised when LAYER_SEQ_TIMEOUT_EN is defined.
module tb_layer_seq;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int SW = 3;

  logic            clk = 1'b0;
  logic            srstn = 1'b0;
  logic            enable = 1'b0;
  logic            abort = 1'b0;
  logic [SW-1:0]   num_stages_cfg = '0;
  logic [NS-1:0]   sub_done = '0;
  logic [NS*DW-1:0] sub_data_out;
  logic [NS*AW-1:0] sub_addr_in;
  logic [NS*AW-1:0] sub_addr_out;
  logic [NS-1:0]   sub_en_wr = 4'b0101;
  logic [NS-1:0]   sub_en_rd = 4'b1010;
  logic [NS-1:0]   sub_en;
  logic [DW-1:0]   data_out;
  logic [AW-1:0]   addr_in;
  logic [AW-1:0]   addr_out;
  logic            dram_en_wr;
  logic            dram_en_rd;
  logic [SW-1:0]   stage_idx;
  logic            busy;
  logic            done;
  logic            error;

  int n_total = 0;
  int n_pass  = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int max_idx  = 0;

  always #5 clk = ~clk;

  layer_seq #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .NUM_STAGES (NS), .TIMEOUT_CYCLES (20)
  ) dut (
    .clk (clk), .srstn (srstn), .enable (enable), .abort (abort),
    .num_stages_cfg (num_stages_cfg), .sub_done (sub_done),
    .sub_data_out (sub_data_out), .sub_addr_in (sub_addr_in),
    .sub_addr_out (sub_addr_out), .sub_en_wr (sub_en_wr), .sub_en_rd (sub_en_rd),
    .sub_en (sub_en), .data_out (data_out), .addr_in (addr_in),
    .addr_out (addr_out), .dram_en_wr (dram_en_wr), .dram_en_rd (dram_en_rd),
    .stage_idx (stage_idx), .busy (busy), .done (done), .error (error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (error) err_cnt++;
    if (int'(stage_idx) > max_idx) max_idx = int'(stage_idx);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".sub_en"}, 64'(sub_en), 64'h0);
    check({tag, ".busy"}, 64'(busy), 64'h0);
    check({tag, ".dram"}, {data_out, addr_in, dram_en_wr, dram_en_rd}, 64'h0);
    check({tag, ".addr_out"}, 64'(addr_out), 64'h0);
  endtask

  // Engine k drives data A000_000k, addr_in 0x10k, addr_out 0x20k;
  // write strobes 0101, read strobes 1010.
  task automatic check_run(input string tag, input int s);
    logic [3:0] oh;
    oh = 4'b0001 << s;
    check({tag, ".sub_en"}, 64'(sub_en), 64'(oh));
    check({tag, ".stage_idx"}, 64'(stage_idx), 64'(s));
    check({tag, ".data_out"}, 64'(data_out), 64'hA000_0000 + 64'(s));
    check({tag, ".addr"}, {addr_in, addr_out}, {18'h100 + 18'(s), 18'h200 + 18'(s)});
    check({tag, ".wr_rd"}, {dram_en_wr, dram_en_rd}, ((s % 2) == 0) ? 64'b10 : 64'b01);
  endtask

  initial begin
    for (int k = 0; k < NS; k++) begin
      sub_data_out[k*DW +: DW] = 32'hA000_0000 + 32'(k);
      sub_addr_in[k*AW +: AW]  = 18'h100 + 18'(k);
      sub_addr_out[k*AW +: AW] = 18'h200 + 18'(k);
    end

    // Reset
    step(); step();
    check_idle("reset");
    check("reset.stage_idx", 64'(stage_idx), 64'h0);
    check("reset.done_err", {done, error}, 64'h0);
    srstn = 1'b1;
    step();

    // Three stages, each engine done in the 10th enabled cycle
    busy_cnt = 0; done_cnt = 0;
    num_stages_cfg = 3'd3;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check_run($sformatf("seq3.run%0d", s), s);
      for (int c = 0; c < 9; c++) step();
      check($sformatf("seq3.hold%0d", s), 64'(sub_en), 64'(4'b0001 << s));
      sub_done = 4'b0001 << s;
      step();
      sub_done = '0;
      if (s < 2) begin
        check($sformatf("seq3.gap%0d", s), {sub_en, busy, stage_idx}, {4'b0000, 1'b1, 3'(s + 1)});
        check($sformatf("seq3.gapdata%0d", s), 64'(data_out), 64'h0);
        step();
      end
    end
    check("seq3.done", {done, busy, sub_en}, {1'b1, 1'b0, 4'b0000});
    step();
    check("seq3.done_pulse", 64'(done), 64'h0);
    check("seq3.busy_cycles", 64'(busy_cnt), 64'd32);
    check("seq3.done_count", 64'(done_cnt), 64'd1);

    // Zero stages
    num_stages_cfg = 3'd0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    check("cfg0.done", {done, busy, sub_en}, {1'b1, 1'b0, 4'b0000});
    step();
    check("cfg0.after", {done, busy, sub_en}, 64'h0);

    // Clamp 7 -> 4 stages, engines finish immediately
    max_idx = 0;
    num_stages_cfg = 3'd7;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int s = 0; s < 4; s++) begin
      check_run($sformatf("clamp.run%0d", s), s);
      sub_done = 4'b0001 << s;
      step();
      sub_done = '0;
      if (s < 3) step();
    end
    check("clamp.done", {done, stage_idx}, {1'b1, 3'd3});
    check("clamp.max_idx", 64'(max_idx), 64'd3);
    step();

    // Foreign done bits ignored; done ignored during gap; enable ignored while busy
    num_stages_cfg = 3'd4;
    enable = 1'b1;
    step();
    enable = 1'b0;
    sub_done = 4'b0001;
    step();
    sub_done = '0;
    step();
    enable = 1'b1;
    sub_done = 4'b0101;
    step();
    check_run("foreign.hold", 1);
    enable = 1'b0;
    sub_done = 4'b0010;
    step();
    check("foreign.gap", {sub_en, busy, stage_idx}, {4'b0000, 1'b1, 3'd2});
    sub_done = 4'b0100;
    step();
    sub_done = '0;
    check_run("gapdone.ignored", 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("abort2");

    // Abort beats a simultaneous done in stage 1
    done_cnt = 0;
    num_stages_cfg = 3'd3;
    enable = 1'b1;
    step();
    enable = 1'b0;
    sub_done = 4'b0001;
    step();
    sub_done = '0;
    step();
    check_run("abort.pre", 1);
    abort = 1'b1;
    sub_done = 4'b0010;
    step();
    abort = 1'b0;
    sub_done = '0;
    check_idle("abort.win");
    check("abort.idx_done", {stage_idx, done}, 64'h0);
    step();
    check("abort.no_done", 64'(done_cnt), 64'd0);

    // Reset mid-sequence
    done_cnt = 0; err_cnt = 0;
    num_stages_cfg = 3'd2;
    enable = 1'b1;
    step();
    enable = 1'b0;
    check_run("rst.pre", 0);
    srstn = 1'b0;
    step();
    check_idle("rst.mid");
    srstn = 1'b1;
    step(); step();
    check("rst.no_pulse", {32'(done_cnt), 32'(err_cnt)}, 64'h0);

`ifdef LAYER_SEQ_TIMEOUT_EN
    // Engine never finishes: error 20 cycles after entering ST_RUN
    err_cnt = 0;
    num_stages_cfg = 3'd1;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int c = 0; c < 19; c++) step();
    check("to.still_run", {error, busy, sub_en}, {1'b0, 1'b1, 4'b0001});
    step();
    check("to.error", {error, busy, done, sub_en}, {1'b1, 1'b0, 1'b0, 4'b0000});
    step();
    check("to.idle", {error, busy}, 64'h0);
    check("to.err_count", 64'(err_cnt), 64'd1);
`else
    // Without the watchdog a hung engine simply keeps the sequence running
    err_cnt = 0;
    num_stages_cfg = 3'd1;
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int c = 0; c < 25; c++) step();
    check("noto.running", {error, busy, sub_en}, {1'b0, 1'b1, 4'b0001});
    check("noto.err_count", 64'(err_cnt), 64'd0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_idle("noto.abort");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/layer_seq.md
LAYER_SEQ -- requirements
Module: layer_seq

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH, 32, DRAM data width; ADDR_WIDTH, 18, DRAM address width; NUM_STAGES, 4, number of attached layer engines (1..16); TIMEOUT_CYCLES, 65535, per-stage watchdog limit; STG_W, $clog2(NUM_STAGES+1), stage-count width.
REQ-002 clk  in  1  clock; srstn  in  1  reset, synchronous, active-low.
REQ-003 enable  in  1  start request, sampled in ST_IDLE only.
REQ-004 abort  in  1  abandon sequence, returns to ST_IDLE.
REQ-005 num_stages_cfg  in  STG_W  stages to run, latched at start.
REQ-006 sub_done  in  NUM_STAGES  per-engine done strobes.
REQ-007 sub_data_out  in  NUM_STAGES*DATA_WIDTH  flattened engine write data; engine k occupies slice [k*DATA_WIDTH +: DATA_WIDTH]; sub_addr_in, sub_addr_out are flattened the same way at ADDR_WIDTH.
REQ-008 sub_en_wr, sub_en_rd  in  NUM_STAGES  per-engine DRAM strobes.
REQ-009 sub_en  out  NUM_STAGES  one-hot engine enable.
REQ-010 data_out  out  DATA_WIDTH; addr_in, addr_out  out  ADDR_WIDTH; dram_en_wr, dram_en_rd  out  1: forwarded DRAM port.
REQ-011 stage_idx  out  STG_W  current stage; busy  out  1; done  out  1  one-cycle completion pulse; error  out  1  one-cycle timeout pulse.

Function
REQ-012 FSM states: ST_IDLE, ST_RUN, ST_GAP, ST_DONE, ST_ERR; state and stage_idx registered.
REQ-013 ST_IDLE with enable=1: latch cfg = min(num_stages_cfg, NUM_STAGES) and set stage_idx=0; if cfg=0 go to ST_DONE, else go to ST_RUN.
REQ-014 ST_RUN: sub_en has a single bit set at position stage_idx; the DRAM outputs combinationally forward engine stage_idx's slice.
REQ-015 ST_RUN with sub_done[stage_idx]=1: if stage_idx=cfg-1 go to ST_DONE, else increment stage_idx and go to ST_GAP.
REQ-016 ST_GAP lasts exactly one cycle with sub_en=0, then goes to ST_RUN; this lets each engine see enable fall between runs.
REQ-017 sub_done bits other than sub_done[stage_idx] are ignored in every state, and so is sub_done in ST_GAP.
REQ-018 ST_DONE lasts one cycle with done=1, then goes to ST_IDLE.
REQ-019 Outside ST_RUN, sub_en, data_out, addr_in, addr_out, dram_en_wr and dram_en_rd are 0.
REQ-020 busy=1 in ST_RUN and ST_GAP only.
REQ-021 enable is ignored outside ST_IDLE.
REQ-022 abort=1 in ST_RUN or ST_GAP goes to ST_IDLE next cycle with no done pulse; abort wins over a simultaneous sub_done.
REQ-023 Latency: enable at cycle t puts sub_en[0]=1 at t+1; the last sub_done at cycle u puts done=1 at u+1.

Reset
REQ-024 While srstn=0: state=ST_IDLE, stage_idx=0, cfg=0, timeout counter=0, and every output is 0.
REQ-025 Reset mid-sequence drops sub_en in the following cycle; no done or error pulse is produced.

Configuration
REQ-026 Macro LAYER_SEQ_TIMEOUT_EN defined: a per-stage cycle counter clears when entering ST_RUN and increments each ST_RUN cycle; if it reaches TIMEOUT_CYCLES without sub_done, go to ST_ERR (one cycle, error=1), then to ST_IDLE.
REQ-027 Macro undefined: no counter and no ST_ERR logic; error is tied to 0.

Structure
REQ-028 A shared package lenet_pkg holds the state encoding (3-bit: IDLE=0, RUN=1, GAP=2, DONE=3, ERR=7) and the DATA_WIDTH and ADDR_WIDTH defaults.
REQ-029 The DRAM port multiplexer is a separate sub-module, dram_port_mux, parametrised by NUM_STAGES and the two widths; the FSM lives in layer_seq.

Verification
REQ-030 NUM_STAGES=4, cfg=3, each engine pulses done after 10 cycles -> sub_en sequence 0001,0000,0010,0000,0100; a single done; busy for 32 cycles.
REQ-031 cfg=0 with enable -> done one cycle later; sub_en stays 0.
REQ-032 cfg=7 with NUM_STAGES=4 -> clamped to 4 stages; stage_idx never exceeds 3.
REQ-033 In stage 1, sub_done=4'b0101 -> no advance; then 4'b0010 -> advance to ST_GAP.
REQ-034 abort together with sub_done[1] in stage 1 -> ST_IDLE; done=0; all outputs 0 next cycle.
REQ-035 With LAYER_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=20, the engine never finishes -> error pulse 20 cycles after entering ST_RUN, then ST_IDLE.
